// File: rtl/bram_fifo_ctrl_pkg.sv
// rtl/bram_fifo_ctrl_pkg.sv - shared op encodings and depth helper for the BRAM FIFO controller
package bram_fifo_ctrl_pkg;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  function automatic int unsigned f_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/bram_fifo_ctrl_if.sv
// rtl/bram_fifo_ctrl_if.sv - stream in/out, fill level and single-port BRAM bundle
interface bram_fifo_ctrl_if #(
  parameter int WIDTH = 24,
  parameter int AW    = 12
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [AW:0]      level;
  logic             bram_en;
  logic             bram_we;
  logic [AW-1:0]    bram_addr;
  logic [WIDTH-1:0] bram_din;
  logic [WIDTH-1:0] bram_dout;

  modport master (
    output s_valid, s_data, m_ready, bram_dout,
    input  s_ready, m_valid, m_data, level, bram_en, bram_we, bram_addr, bram_din
  );

  modport slave (
    input  s_valid, s_data, m_ready, bram_dout,
    output s_ready, m_valid, m_data, level, bram_en, bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/bram_fifo_ctrl_outq.sv
// rtl/bram_fifo_ctrl_outq.sv - 2-entry registered prefetch queue between BRAM dout and the output stream
module bram_fifo_ctrl_outq #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full,
  output logic [1:0]       o_cnt
);
  logic [WIDTH-1:0] r_mem [0:1];
  logic             r_head;
  logic [1:0]       r_cnt;
  logic             w_pop;
  logic             w_push;
  logic             w_tail;

  assign w_pop  = i_pop && (r_cnt != 2'd0);
  assign w_push = i_push && ((r_cnt != 2'd2) || w_pop);
  // With two entries the tail slot is head when count is even, the other slot when odd.
  assign w_tail = r_head ^ r_cnt[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_push) r_mem[w_tail] <= i_data;
      if (w_pop) r_head <= ~r_head;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_data  = r_mem[r_head];
  assign o_empty = (r_cnt == 2'd0);
  assign o_full  = (r_cnt == 2'd2);
  assign o_cnt   = r_cnt;
endmodule

// File: rtl/bram_fifo_ctrl.sv
// rtl/bram_fifo_ctrl.sv - stream FIFO over a single-port BRAM with round-robin W/R arbitration
// Optional almost_full output enabled by BRAM_FIFO_ALMOST_FULL_EN.
module bram_fifo_ctrl
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int AW    = 12
`ifdef BRAM_FIFO_ALMOST_FULL_EN
  , parameter int AF_THRESH = (1 << AW) - 16
`endif
) (
  input  logic clk,
  input  logic rst,
  bram_fifo_ctrl_if.slave bus
`ifdef BRAM_FIFO_ALMOST_FULL_EN
  , output logic almost_full
`endif
);
  localparam logic [AW:0] DEPTH = (AW+1)'(f_depth(AW));
  localparam logic [AW:0] ONE   = (AW+1)'(1);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_bram_cnt;
  logic             r_inflight;
  op_e              r_last_op;
  logic [AW:0]      w_cnt_next;
  logic [1:0]       w_q_cnt;
  logic             w_q_empty;
  logic             w_q_full;
  logic [WIDTH-1:0] w_q_data;
  logic             w_full;
  logic             w_wr_want;
  logic             w_rd_want;
  logic             w_grant_wr;
  logic             w_grant_rd;

  assign w_full    = (r_bram_cnt == DEPTH);
  assign w_wr_want = bus.s_valid && !w_full;
  // A read is only worth issuing if its result will have a queue slot when it lands.
  assign w_rd_want = (r_bram_cnt != '0) && !w_q_full && !(w_q_cnt[0] && r_inflight);

  assign w_grant_wr = w_wr_want && (!w_rd_want || (r_last_op == OP_READ));
  assign w_grant_rd = w_rd_want && !w_grant_wr;

  assign bus.s_ready   = !rst && !w_full && !(w_rd_want && (r_last_op == OP_WRITE));
  assign bus.bram_en   = !rst && (w_grant_wr || w_grant_rd);
  assign bus.bram_we   = !rst && w_grant_wr;
  assign bus.bram_addr = rst ? '0 : (w_grant_rd ? r_rd_ptr : r_wr_ptr);
  assign bus.bram_din  = bus.s_data;

  always_comb begin
    w_cnt_next = r_bram_cnt;
    if (w_grant_wr) w_cnt_next = r_bram_cnt + ONE;
    else if (w_grant_rd) w_cnt_next = r_bram_cnt - ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_bram_cnt <= '0;
      r_inflight <= 1'b0;
      r_last_op  <= OP_READ;
    end else begin
      if (w_grant_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_grant_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_grant_wr || w_grant_rd) r_last_op <= w_grant_wr ? OP_WRITE : OP_READ;
      r_bram_cnt <= w_cnt_next;
      r_inflight <= w_grant_rd;
    end
  end

  bram_fifo_ctrl_outq #(.WIDTH(WIDTH)) u_outq (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_data  (bus.bram_dout),
    .i_pop   (bus.m_ready),
    .o_data  (w_q_data),
    .o_empty (w_q_empty),
    .o_full  (w_q_full),
    .o_cnt   (w_q_cnt)
  );

  assign bus.m_valid = !w_q_empty;
  assign bus.m_data  = w_q_data;
  assign bus.level   = r_bram_cnt + (AW+1)'(r_inflight) + (AW+1)'(w_q_cnt);

`ifdef BRAM_FIFO_ALMOST_FULL_EN
  logic r_almost_full;

  always_ff @(posedge clk) begin
    if (rst) r_almost_full <= 1'b0;
    else     r_almost_full <= (32'(w_cnt_next) >= 32'(AF_THRESH));
  end

  assign almost_full = r_almost_full;
`endif
endmodule
